key_event_calc: RTL

Calculator core that consumes the decoded key-event stream produced by the keypad scanner: `is_num`/`is_op`/`is_eq` strobes with `num_val`/`op_val`. It assembles two decimal operands digit by digit, latches the operator, and computes the result on `=`. Division runs through a multi-cycle restoring divider. The block runs in the scanner's clock domain (LF oscillator) and drives a signed value for the display path.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/seq_divider.sv | 66 ++++++
 rtl/key_event_calc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: FSM states, operator codes and default widths.
// The operator codes are also used by the keypad scanner's op_val decoder.
package calc_pkg;

  localparam int unsigned DEF_MAX_DIGITS = 4;
  localparam int unsigned DEF_OPERAND_W  = 14;
  localparam int unsigned DEF_RESULT_W   = 28;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    DIVIDE,
    SHOW
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W iterations total.
// The first iteration runs on the start edge, so done pulses W cycles after start.
module seq_divider #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_rem, r_quo, r_dsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done;

  logic [W-1:0] w_rem_in, w_quo_in, w_dsr, w_rem_nx, w_quo_nx;
  logic [W:0]   w_shift;
  logic         w_ge;

  assign w_rem_in = start ? '0 : r_rem;
  assign w_quo_in = start ? dividend : r_quo;
  assign w_dsr    = start ? divisor : r_dsr;
  assign w_shift  = {w_rem_in, w_quo_in[W-1]};
  assign w_ge     = w_shift >= {1'b0, w_dsr};
  assign w_rem_nx = w_ge ? W'(w_shift - {1'b0, w_dsr}) : w_shift[W-1:0];
  assign w_quo_nx = {w_quo_in[W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dsr  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= w_rem_nx;
        r_quo  <= w_quo_nx;
        r_dsr  <= divisor;
        r_cnt  <= CNT_W'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/key_event_calc.sv
// Calculator core: assembles decimal operands from key strobes, latches the
// operator and produces a signed result; division is delegated to seq_divider.
module key_event_calc
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int unsigned OPERAND_W  = DEF_OPERAND_W,
  parameter int unsigned RESULT_W   = DEF_RESULT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                is_num,
  input  logic                is_op,
  input  logic                is_eq,
  input  logic [3:0]          num_val,
  input  logic [1:0]          op_val,
  output logic [RESULT_W-1:0] disp_val,
  output logic                result_valid,
  output logic                busy,
  output logic                err
);

  localparam int unsigned CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam int unsigned MAX_VAL = 10 ** MAX_DIGITS - 1;
  localparam int unsigned PAD_W   = RESULT_W - OPERAND_W;

  state_t                      r_state, w_state_n;
  logic [OPERAND_W-1:0]        r_a, r_b, w_a_n, w_b_n;
  logic [CNT_W-1:0]            r_cnt, w_cnt_n;
  op_t                         r_op, w_op_n;
  logic signed [RESULT_W-1:0]  r_res, w_res_n, r_disp, w_disp_n;
  logic                        r_err, w_err_n, r_valid, r_busy;

  logic signed [RESULT_W-1:0]  w_a_ext, w_b_ext;
  logic [OPERAND_W-1:0]        w_a_dig, w_b_dig, w_quo;
  logic                        w_digit_ok, w_room, w_chain_ok;
  logic                        w_div_start, w_div_busy, w_div_done;

  assign w_a_ext    = {{PAD_W{1'b0}}, r_a};
  assign w_b_ext    = {{PAD_W{1'b0}}, r_b};
  assign w_a_dig    = r_a * OPERAND_W'(10) + OPERAND_W'(num_val);
  assign w_b_dig    = r_b * OPERAND_W'(10) + OPERAND_W'(num_val);
  assign w_digit_ok = is_num && (num_val <= 4'd9);
  assign w_room     = r_cnt < CNT_W'(MAX_DIGITS);
  assign w_chain_ok = !r_err && !r_res[RESULT_W-1] && (r_res <= RESULT_W'(MAX_VAL));

  seq_divider #(.W(OPERAND_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend (r_a),
    .divisor  (r_b),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  // Priority eq > op > num falls out of the if/else-if ordering in each state.
  always_comb begin
    w_state_n   = r_state;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_cnt_n     = r_cnt;
    w_op_n      = r_op;
    w_res_n     = r_res;
    w_err_n     = r_err;
    w_div_start = 1'b0;
    case (r_state)
      ENTER_A: begin
        if (is_eq) begin
          w_res_n   = w_a_ext;
          w_state_n = SHOW;
        end else if (is_op) begin
          w_op_n    = op_t'(op_val);
          w_b_n     = '0;
          w_cnt_n   = '0;
          w_state_n = ENTER_B;
        end else if (w_digit_ok && w_room) begin
          w_a_n   = w_a_dig;
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      ENTER_B: begin
        if (is_eq) begin
          w_state_n = SHOW;
          case (r_op)
            OP_ADD: w_res_n = w_a_ext + w_b_ext;
            OP_SUB: w_res_n = w_a_ext - w_b_ext;
            OP_MUL: w_res_n = w_a_ext * w_b_ext;
            default: begin
              if (r_b != '0) begin
                w_div_start = 1'b1;
                w_state_n   = DIVIDE;
              end else begin
                w_res_n = '0;
                w_err_n = 1'b1;
              end
            end
          endcase
        end else if (is_op) begin
          w_op_n = op_t'(op_val);
        end else if (w_digit_ok && w_room) begin
          w_b_n   = w_b_dig;
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      DIVIDE: begin
        if (w_div_done) begin
          w_res_n   = {{PAD_W{1'b0}}, w_quo};
          w_state_n = SHOW;
        end
      end
      SHOW: begin
        if (!is_eq) begin
          if (is_op) begin
            if (w_chain_ok) begin
              w_a_n     = r_res[OPERAND_W-1:0];
              w_op_n    = op_t'(op_val);
              w_b_n     = '0;
              w_cnt_n   = '0;
              w_state_n = ENTER_B;
            end
          end else if (w_digit_ok) begin
            w_a_n     = OPERAND_W'(num_val);
            w_cnt_n   = CNT_W'(1);
            w_err_n   = 1'b0;
            w_state_n = ENTER_A;
          end
        end
      end
      default: w_state_n = ENTER_A;
    endcase

    w_disp_n = r_disp;
    case (w_state_n)
      ENTER_A: w_disp_n = {{PAD_W{1'b0}}, w_a_n};
      ENTER_B: w_disp_n = {{PAD_W{1'b0}}, w_b_n};
      SHOW:    w_disp_n = w_res_n;
      default: w_disp_n = r_disp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_disp  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_cnt   <= w_cnt_n;
      r_op    <= w_op_n;
      r_res   <= w_res_n;
      r_err   <= w_err_n;
      r_disp  <= w_disp_n;
      r_valid <= (w_state_n == SHOW) && (r_state != SHOW);
      r_busy  <= w_div_start || w_div_busy;
    end
  end

  assign disp_val     = r_disp;
  assign result_valid = r_valid;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
